// File: rtl/button_pkg.sv
// Shared constants for the push-button conditioning block: register map,
// button count limit and the debounce counter width helper.
package button_pkg;

  localparam logic [1:0] ADDR_DATA         = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK     = 2'd1;
  localparam logic [1:0] ADDR_EDGE_CAPTURE = 2'd2;

  localparam int MAX_BTN = 16;

  // Counter must reach DEBOUNCE_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(input int debounce_cycles);
    return (debounce_cycles < 2) ? 1 : $clog2(debounce_cycles);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button: 2-FF synchroniser, polarity normalisation, stability counter,
// debounced level and one-cycle press/release strobes.
module debounce_cell
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // The synchroniser resets to the released pin level so that reset
  // deassertion never looks like a press.
  localparam logic PIN_RELEASED = BTN_ACTIVE_LOW;

  logic          sync1;
  logic          sync2;
  logic          s;
  logic [CW-1:0] cnt;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= PIN_RELEASED;
      sync2 <= PIN_RELEASED;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  assign s = BTN_ACTIVE_LOW ? ~sync2 : sync2;

  // Accept a new level only after it has differed from the current one for
  // DEBOUNCE_CYCLES consecutive cycles; strobes fire with the level change.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      if (s == btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt         <= '0;
        btn_level   <= s;
        btn_press   <= s;
        btn_release <= ~s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_debounce_capture.sv
// Push-button front end for the processor: per-button debounce cells plus an
// Avalon-MM slave with DATA / IRQ_MASK / EDGE_CAPTURE and a level interrupt.
module button_debounce_capture
  import button_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_BTN-1:0] button,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  logic [N_BTN-1:0] irq_mask;
  logic [N_BTN-1:0] edge_capture;
  logic [N_BTN-1:0] ec_clear;
  logic [31:0]      rd_next;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_cell
      debounce_cell #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
      ) u_cell (
        .clock       (clock),
        .reset       (reset),
        .button      (button[gi]),
        .btn_level   (btn_level[gi]),
        .btn_press   (btn_press[gi]),
        .btn_release (btn_release[gi])
      );
    end
  endgenerate

  // Bits above N_BTN of the write data carry no register state.
  generate
    if (N_BTN < 32) begin : g_wd_unused
      logic unused_wdata;
      assign unused_wdata = ^avs_writedata[31:N_BTN];
    end
  endgenerate

  assign ec_clear = (avs_write && avs_address == ADDR_EDGE_CAPTURE) ?
                    avs_writedata[N_BTN-1:0] : '0;

  // Register file: IRQ_MASK is plain R/W; EDGE_CAPTURE is W1C with set priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (avs_write && avs_address == ADDR_IRQ_MASK)
        irq_mask <= avs_writedata[N_BTN-1:0];
      edge_capture <= (edge_capture & ~ec_clear) | btn_press;
    end
  end

  // Read mux from current register state, so a same-cycle write is not visible.
  always_comb begin
    rd_next = '0;
    case (avs_address)
      ADDR_DATA:         rd_next[N_BTN-1:0] = btn_level;
      ADDR_IRQ_MASK:     rd_next[N_BTN-1:0] = irq_mask;
      ADDR_EDGE_CAPTURE: rd_next[N_BTN-1:0] = edge_capture;
      default:           rd_next = '0;
    endcase
  end

  // Fixed read latency of one; data holds between reads.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      avs_readdata <= '0;
    else if (avs_read)
      avs_readdata <= rd_next;
  end

  // Registered level interrupt, one cycle behind the register state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      irq <= 1'b0;
    else
      irq <= |(edge_capture & irq_mask);
  end

endmodule

// File: tb/tb_button_debounce_capture.sv
// Bench for button_debounce_capture with DEBOUNCE_CYCLES = 8, four active-low buttons.
module tb_button_debounce_capture;

  localparam int N  = 4;
  localparam int DC = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [N-1:0] button = 4'hF;
  logic [N-1:0] btn_level, btn_press, btn_release;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        irq;

  button_debounce_capture #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (DC),
    .BTN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .button        (button),
    .btn_level     (btn_level),
    .btn_press     (btn_press),
    .btn_release   (btn_release),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];
  string       sb_tag[$];
  int press_cnt[N]   = '{default: 0};
  int release_cnt[N] = '{default: 0};

  // Strobe tallies, sampled away from the active edge.
  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (btn_press[i])   press_cnt[i]   = press_cnt[i] + 1;
      if (btn_release[i]) release_cnt[i] = release_cnt[i] + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    avs_write = 1'b1; avs_address = addr; avs_writedata = data;
    step(1);
    avs_write = 1'b0; avs_writedata = 32'd0;
  endtask

  task automatic sb_pop_check();
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 32'd1, 32'd0);
    end else begin
      string t;
      logic [31:0] e;
      t = sb_tag.pop_front();
      e = sb_q.pop_front();
      check_val(t, avs_readdata, e);
    end
  endtask

  task automatic bus_read(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    avs_read = 1'b1; avs_address = addr;
    sb_q.push_back(exp); sb_tag.push_back(tag);
    step(1);
    avs_read = 1'b0;
    sb_pop_check();
  endtask

  function automatic logic [31:0] out_vec();
    return {19'd0, irq, btn_release, btn_press, btn_level};
  endfunction

  int p0, r3;

  initial begin
    // 1: reset and quiet release with all pins released
    step(3);
    check_val("rst_outputs", out_vec(), 32'd0);
    check_val("rst_readdata", avs_readdata, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check_val("quiet_outputs", out_vec(), 32'd0);
    end
    check_val("quiet_strobes", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]
                                    + release_cnt[0] + release_cnt[1] + release_cnt[2] + release_cnt[3]), 32'd0);

    // 2: button 0 press latency, strobe width, capture and DATA readback
    p0 = press_cnt[0];
    button[0] = 1'b0;
    step(DC + 1);
    check_val("b0_level_early", 32'(btn_level[0]), 32'd0);
    step(1);
    check_val("b0_level_rise", 32'(btn_level), 32'h1);
    check_val("b0_press_on", 32'(btn_press), 32'h1);
    step(1);
    check_val("b0_press_off", 32'(btn_press), 32'h0);
    check_val("b0_press_count", 32'(press_cnt[0] - p0), 32'd1);
    bus_read(2'd2, 32'h1, "rd_ec_b0");
    bus_read(2'd0, 32'h1, "rd_data_b0");
    step(3);
    check_val("rd_hold", avs_readdata, 32'h1);
    button[0] = 1'b1;
    step(DC + 1);
    check_val("b0_level_hold", 32'(btn_level[0]), 32'd1);
    step(1);
    check_val("b0_release_on", 32'(btn_release), 32'h1);
    check_val("b0_level_fall", 32'(btn_level), 32'h0);
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, 32'h0, "rd_ec_cleared");
    bus_write(2'd0, 32'hF);
    bus_read(2'd0, 32'h0, "rd_data_ro");
    bus_write(2'd3, 32'hF);
    bus_read(2'd3, 32'h0, "rd_addr3");
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, 32'hF, "rd_mask_trunc");

    // 3: bouncing button 1
    p0 = press_cnt[1];
    button[1] = 1'b0; step(5);
    button[1] = 1'b1; step(2);
    button[1] = 1'b0;
    step(DC + 1);
    check_val("b1_level_early", 32'(btn_level[1]), 32'd0);
    step(1);
    check_val("b1_level_rise", 32'(btn_level[1]), 32'd1);
    step(2);
    check_val("b1_press_count", 32'(press_cnt[1] - p0), 32'd1);
    button[1] = 1'b1;
    step(DC + 4);
    bus_write(2'd2, 32'h2);
    bus_read(2'd2, 32'h0, "rd_ec_b1_clr");

    // 4: interrupt timing and W1C clear
    bus_write(2'd1, 32'h1);
    button[0] = 1'b0;
    step(DC + 2);
    check_val("irq_at_press", 32'(irq), 32'd0);
    check_val("b0_press2", 32'(btn_press[0]), 32'd1);
    step(1);
    check_val("irq_ec_set", 32'(irq), 32'd0);
    step(1);
    check_val("irq_rise", 32'(irq), 32'd1);
    bus_write(2'd2, 32'h1);
    check_val("irq_clear_lag", 32'(irq), 32'd1);
    step(1);
    check_val("irq_fall", 32'(irq), 32'd0);
    bus_read(2'd2, 32'h0, "rd_ec_after_w1c");

    // 5: W1C colliding with a press, set wins; bit 2 is masked off
    button[2] = 1'b0;
    step(DC + 2);
    check_val("b2_press", 32'(btn_press[2]), 32'd1);
    bus_write(2'd2, 32'h4);
    bus_read(2'd2, 32'h4, "rd_ec_set_wins");
    step(1);
    check_val("irq_masked", 32'(irq), 32'd0);

    // simultaneous read and write returns pre-write value
    avs_read = 1'b1; avs_write = 1'b1; avs_address = 2'd1; avs_writedata = 32'hA;
    sb_q.push_back(32'h1); sb_tag.push_back("rd_wr_same");
    step(1);
    avs_read = 1'b0; avs_write = 1'b0; avs_writedata = 32'd0;
    sb_pop_check();
    bus_read(2'd1, 32'hA, "rd_mask_new");

    button = 4'hF;
    step(DC + 4);
    check_val("all_released", 32'(btn_level), 32'h0);

    // 6: reset in the middle of a count on button 3
    r3 = release_cnt[3];
    button[3] = 1'b0;
    step(7);
    reset = 1'b0;
    #1;
    check_val("rst6_outputs", out_vec(), 32'd0);
    step(3);
    check_val("rst6_hold", out_vec(), 32'd0);
    reset = 1'b1;
    step(DC + 1);
    check_val("b3_level_early", 32'(btn_level), 32'h0);
    step(1);
    check_val("b3_level_rise", 32'(btn_level), 32'h8);
    check_val("b3_press", 32'(btn_press), 32'h8);
    step(2);
    check_val("b3_no_release", 32'(release_cnt[3] - r3), 32'd0);
    bus_read(2'd1, 32'h0, "rd_mask_reset");
    bus_read(2'd2, 32'h8, "rd_ec_b3");

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
